// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array input/output interface.
//   skew_state_t : sequencing state of the skew feeder
//   slot_of      : maps column c of an n-wide row to its bus slot (column 0 is the MSB slot)
//   cnt_width    : width of the row/flush counters
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        FLUSH
    } skew_state_t;

    function automatic int slot_of(input int c, input int n);
        return n - 1 - c;
    endfunction

    function automatic int cnt_width(input int rows, input int inputs);
        return $clog2(rows + inputs) + 1;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Per-lane delay chain of the skew feeder.
//   clk : clock, rising edge
//   res : synchronous active-high reset, clears every stage
//   en  : shift enable; all stages advance together
//   d   : value loaded into stage 0 on a shift
//   q   : last stage, Depth shifts after d was loaded
module skew_delay_line #(
    parameter int BitSize = 8,
    parameter int Depth   = 1
) (
    input  logic               clk,
    input  logic               res,
    input  logic               en,
    input  logic [BitSize-1:0] d,
    output logic [BitSize-1:0] q
);

    logic [BitSize-1:0] stage [Depth];

    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < Depth; i++) begin
                stage[i] <= '0;
            end
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < Depth; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[Depth-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Transmit side of the systolic array's diagonal input interface. Accepts one
// row of A per handshake and emits the skewed stream: column c is delayed by
// c steps, empty lanes carry zero, and after the last row zeros are flushed
// until the final diagonal has left.
//
//   clk            : clock, rising edge
//   res            : synchronous active-high reset
//   in_valid       : upstream row available
//   in_row         : one row of A, column 0 in the MSB slot
//   in_ready       : row accepted when in_valid && in_ready
//   in_array_ready : array has weights loaded; sampled only in IDLE
//   in_stall       : downstream freeze, nothing advances while high
//   out_valid      : diagonal present on out_data (array in_valid)
//   out_start      : first diagonal of a matrix (array in_start)
//   out_data       : skewed diagonal, same slot order as in_row
//   out_done       : last diagonal of a matrix
//   out_busy       : a matrix is in progress
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for the first row of a matrix and in_array_ready
// FEED  | rows 1..NumOfRows-1 being accepted; bubbles are not steps
// FLUSH | shifting zeros until the last diagonal is out
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int BitSize     = 8,
    parameter int NumOfInputs = 2,
    parameter int NumOfRows   = 2
) (
    input  logic                           clk,
    input  logic                           res,
    input  logic                           in_valid,
    input  logic [NumOfInputs*BitSize-1:0] in_row,
    output logic                           in_ready,
    input  logic                           in_array_ready,
    input  logic                           in_stall,
    output logic                           out_valid,
    output logic                           out_start,
    output logic [NumOfInputs*BitSize-1:0] out_data,
    output logic                           out_done,
    output logic                           out_busy
);

    localparam int CntW = cnt_width(NumOfRows, NumOfInputs);
    localparam logic [CntW-1:0] LastRow   = CntW'(NumOfRows - 1);
    // Only reachable when NumOfInputs > 1; the guard keeps the constant non-negative.
    localparam logic [CntW-1:0] LastFlush = CntW'((NumOfInputs > 1) ? NumOfInputs - 2 : 0);

    skew_state_t     state, state_nxt;
    logic [CntW-1:0] row_cnt, row_cnt_nxt;
    logic [CntW-1:0] flush_cnt, flush_cnt_nxt;
    logic            ready;
    logic            step;
    logic            final_step;

    always_comb begin
        state_nxt     = state;
        row_cnt_nxt   = row_cnt;
        flush_cnt_nxt = flush_cnt;
        ready         = 1'b0;
        step          = 1'b0;
        final_step    = 1'b0;
        case (state)
            IDLE: begin
                ready = in_array_ready && !in_stall && !res;
                if (in_valid && ready) begin
                    step          = 1'b1;
                    row_cnt_nxt   = CntW'(1);
                    flush_cnt_nxt = '0;
                    if (NumOfRows == 1) begin
                        if (NumOfInputs == 1) begin
                            final_step = 1'b1;
                        end else begin
                            state_nxt = FLUSH;
                        end
                    end else begin
                        state_nxt = FEED;
                    end
                end
            end
            FEED: begin
                ready = !in_stall && !res;
                if (in_valid && ready) begin
                    step        = 1'b1;
                    row_cnt_nxt = row_cnt + CntW'(1);
                    if (row_cnt == LastRow) begin
                        flush_cnt_nxt = '0;
                        if (NumOfInputs == 1) begin
                            final_step = 1'b1;
                            state_nxt  = IDLE;
                        end else begin
                            state_nxt = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (!in_stall) begin
                    step          = 1'b1;
                    flush_cnt_nxt = flush_cnt + CntW'(1);
                    if (flush_cnt == LastFlush) begin
                        final_step = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            row_cnt   <= '0;
            flush_cnt <= '0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            row_cnt   <= row_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
            out_valid <= step;
            out_start <= step && (state == IDLE);
            out_done  <= final_step;
        end
    end

    // Each lane's index is an elaboration constant, so lanes can never alias.
    for (genvar c = 0; c < NumOfInputs; c++) begin : g_lane
        localparam int Slot = slot_of(c, NumOfInputs);
        logic [BitSize-1:0] lane_d;

        assign lane_d = (state == FLUSH) ? '0 : in_row[Slot*BitSize +: BitSize];

        skew_delay_line #(
            .BitSize(BitSize),
            .Depth  (c + 1)
        ) u_lane (
            .clk(clk),
            .res(res),
            .en (step),
            .d  (lane_d),
            .q  (out_data[Slot*BitSize +: BitSize])
        );
    end

    assign in_ready = ready;
    assign out_busy = (state != IDLE);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;

    logic        clk = 1'b0;
    logic        res;
    logic        in_array_ready;
    logic        in_stall;

    logic        in_valid;
    logic [31:0] in_row;
    logic        in_ready;
    logic        out_valid, out_start, out_done, out_busy;
    logic [31:0] out_data;

    logic        in_valid1;
    logic [7:0]  in_row1;
    logic        in_ready1;
    logic        out_valid1, out_start1, out_done1, out_busy1;
    logic [7:0]  out_data1;

    logic        in_valid2;
    logic [31:0] in_row2;
    logic        in_ready2;
    logic        out_valid2, out_start2, out_done2, out_busy2;
    logic [31:0] out_data2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.BitSize(8), .NumOfInputs(4), .NumOfRows(4)) dut (
        .clk(clk), .res(res), .in_valid(in_valid), .in_row(in_row), .in_ready(in_ready),
        .in_array_ready(in_array_ready), .in_stall(in_stall),
        .out_valid(out_valid), .out_start(out_start), .out_data(out_data),
        .out_done(out_done), .out_busy(out_busy)
    );

    systolic_skew_feeder #(.BitSize(8), .NumOfInputs(1), .NumOfRows(3)) dut1 (
        .clk(clk), .res(res), .in_valid(in_valid1), .in_row(in_row1), .in_ready(in_ready1),
        .in_array_ready(in_array_ready), .in_stall(in_stall),
        .out_valid(out_valid1), .out_start(out_start1), .out_data(out_data1),
        .out_done(out_done1), .out_busy(out_busy1)
    );

    systolic_skew_feeder #(.BitSize(8), .NumOfInputs(4), .NumOfRows(1)) dut2 (
        .clk(clk), .res(res), .in_valid(in_valid2), .in_row(in_row2), .in_ready(in_ready2),
        .in_array_ready(in_array_ready), .in_stall(in_stall),
        .out_valid(out_valid2), .out_start(out_start2), .out_data(out_data2),
        .out_done(out_done2), .out_busy(out_busy2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // a[r][c] = 0x{r}{c}, matrix mi adds 4 to the row nibble so matrices differ
    function automatic logic [31:0] row_of(input int mi, input int r);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) v[(3-c)*8 +: 8] = 8'(((r + 4*mi) << 4) | c);
        return v;
    endfunction

    function automatic logic [31:0] diag_of(input int mi, input int k);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) begin
            if (k - c >= 0 && k - c < 4) v[(3-c)*8 +: 8] = 8'(((k - c + 4*mi) << 4) | c);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds nmat matrices to the 4x4 instance and checks every output cycle.
    task automatic run_main(input string tag, input int nmat, input int bub_after,
                            input int bub_len, input int stall_len);
        int k = 0, sent = 0, bub = 0, stl = 0, gaps = 0, cyc = 0;
        logic acc;
        while (k < 7*nmat && cyc < 200) begin
            in_stall = 1'b0;
            if (k == 5 && stl < stall_len) begin
                in_stall = 1'b1;
                stl++;
            end
            if (sent == bub_after && bub < bub_len) begin
                in_valid = 1'b0;
                bub++;
            end else if (sent < 4*nmat) begin
                in_valid = 1'b1;
                in_row   = row_of(sent / 4, sent % 4);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
            if (out_valid) begin
                check({tag, "_data"},  64'(out_data),  64'(diag_of(k / 7, k % 7)));
                check({tag, "_start"}, 64'(out_start), 64'(k % 7 == 0));
                check({tag, "_done"},  64'(out_done),  64'(k % 7 == 6));
                if (k % 7 == 6) check({tag, "_busy_end"}, 64'(out_busy), 64'(0));
                k++;
            end else if (k > 0) begin
                check({tag, "_held"}, 64'(out_data), 64'(diag_of((k-1) / 7, (k-1) % 7)));
                gaps++;
            end
            cyc++;
        end
        check({tag, "_count"}, 64'(k), 64'(7*nmat));
        check({tag, "_gaps"}, 64'(gaps), 64'(bub_len + stall_len));
        in_valid = 1'b0;
        in_stall = 1'b0;
        tick();
    endtask

    logic [7:0] rows1 [3];
    int k1, s1;
    logic acc1;

    initial begin
        rows1[0] = 8'hA1; rows1[1] = 8'hB2; rows1[2] = 8'hC3;
        res = 1'b1;
        in_array_ready = 1'b1;
        in_stall = 1'b0;
        in_valid = 1'b1; in_row = row_of(0, 0);
        in_valid1 = 1'b0; in_row1 = '0;
        in_valid2 = 1'b0; in_row2 = '0;
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_start", 64'(out_start), 64'(0));
        check("rst_done",  64'(out_done),  64'(0));
        check("rst_data",  64'(out_data),  64'(0));
        check("rst_ready", 64'(in_ready),  64'(0));
        check("rst_busy",  64'(out_busy),  64'(0));
        in_valid = 1'b0;
        res = 1'b0;
        tick();

        run_main("basic", 1, 99, 0, 0);
        run_main("bubble", 1, 2, 2, 0);
        run_main("stall", 1, 99, 0, 3);

        // stall beats a valid row in IDLE
        in_stall = 1'b1; in_valid = 1'b1; in_row = row_of(0, 0);
        #1;
        check("idle_stall_ready", 64'(in_ready), 64'(0));
        tick();
        check("idle_stall_busy",  64'(out_busy),  64'(0));
        check("idle_stall_valid", 64'(out_valid), 64'(0));
        in_stall = 1'b0; in_valid = 1'b0;

        // array not ready: no accept
        in_array_ready = 1'b0; in_valid = 1'b1;
        #1;
        check("gate_ready", 64'(in_ready), 64'(0));
        tick();
        check("gate_busy", 64'(out_busy), 64'(0));
        in_array_ready = 1'b1;
        run_main("b2b", 2, 99, 0, 0);

        // reset in the middle of FEED
        in_valid = 1'b1; in_row = row_of(0, 0);
        tick();
        in_row = row_of(0, 1);
        tick();
        check("mid_busy", 64'(out_busy), 64'(1));
        in_valid = 1'b0; res = 1'b1;
        tick();
        res = 1'b0;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_start", 64'(out_start), 64'(0));
        check("mid_rst_done",  64'(out_done),  64'(0));
        check("mid_rst_data",  64'(out_data),  64'(0));
        check("mid_rst_busy",  64'(out_busy),  64'(0));
        tick();
        run_main("after_rst", 1, 99, 0, 0);

        // one column, three rows: output equals input rows
        k1 = 0; s1 = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid1 = (s1 < 3);
            if (s1 < 3) in_row1 = rows1[s1];
            #1;
            acc1 = in_valid1 && in_ready1;
            tick();
            if (acc1) s1++;
            if (out_valid1) begin
                if (k1 < 3) begin
                    check("n1_data",  64'(out_data1),  64'(rows1[k1]));
                    check("n1_start", 64'(out_start1), 64'(k1 == 0));
                    check("n1_done",  64'(out_done1),  64'(k1 == 2));
                end
                k1++;
            end
        end
        in_valid1 = 1'b0;
        check("n1_count", 64'(k1), 64'(3));
        check("n1_busy",  64'(out_busy1), 64'(0));

        // one row, four columns: four diagonals with one element each
        k1 = 0; s1 = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid2 = (s1 < 1);
            in_row2 = 32'h50515253;
            #1;
            acc1 = in_valid2 && in_ready2;
            tick();
            if (acc1) s1++;
            if (out_valid2) begin
                if (k1 < 4) begin
                    check("m1_data",  64'(out_data2),  64'(32'(8'h50 + k1) << ((3 - k1) * 8)));
                    check("m1_start", 64'(out_start2), 64'(k1 == 0));
                    check("m1_done",  64'(out_done2),  64'(k1 == 3));
                end
                k1++;
            end
        end
        in_valid2 = 1'b0;
        check("m1_count", 64'(k1), 64'(4));
        check("m1_busy",  64'(out_busy2), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
